mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequential arbiter that shares the single external-memory port between three requesters: instruction fetch, data load/store, and the switch/debug loader. It sits between the control unit's memory-request logic and the external memory, upstream of the address/data handlers. It serialises accesses, holds address, data and byte-enables stable for a fixed memory latency, and returns one-hot grant and done pulses plus the registered read word.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (four byte lanes)
- `MEM_LAT`, 2, cycles from `mem_en` to valid `mem_rdata`; legal range 1..15

- `clock`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-low reset
- `req`  in  3  request per requester; bit0 fetch, bit1 data, bit2 debug; level
- `addr_f`, `addr_d`, `addr_g`  in  ADDR_W each  address per requester
- `wdata_d`, `wdata_g`  in  DATA_W each  write data; fetch is read-only
- `we_d`, `we_g`  in  1 each  write enable
- `be_d`, `be_g`  in  4 each  byte enables; fetch always uses 4'b1111
- `gnt`  out  3  one-hot, one-cycle pulse when the request is accepted
- `done`  out  3  one-hot, one-cycle pulse when the access completes
- `rdata`  out  DATA_W  read word, valid while `done` is high, held until the next `done`
- `busy`  out  1  high in every state except IDLE
- `mem_en`  out  1  one-cycle strobe that starts a memory access
- `mem_we`  out  1  write qualifier, held for the whole access
- `mem_addr`  out  ADDR_W  held for the whole access
- `mem_wdata`  out  DATA_W  held for the whole access
- `mem_be`  out  4  held for the whole access
- `mem_rdata`  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE.** On a clock edge with `req` nonzero:
  - select a winner and latch its addr, wdata, we and be into the `mem_*` registers;
  - load `cnt` = MEM_LAT;
  - go to ACCESS.
  - If `req` is zero, stay in IDLE.
- **ACCESS.**
  - The first cycle in ACCESS has `gnt[w]` = 1 and `mem_en` = 1.
  - `cnt` decrements on every edge.
  - On the edge where `cnt` == 1: capture `mem_rdata` into `rdata` (read accesses only; writes leave `rdata` unchanged), then go to DONE.
- **DONE.** `done[w]` = 1 for one cycle, then return to IDLE.
- Requester contract:
  - Hold `req` and the request fields stable until `gnt` is seen.
  - After `gnt`, fields may change.
  - `req` still high on an IDLE edge counts as a new request.
  - A requester that wants one access must drop `req` in its `gnt` cycle or in the following cycle.
- Fixed priority: data > fetch > debug.
- Fetch accesses force `mem_we` = 0 and `mem_be` = 4'b1111.
- `mem_wdata` is zero for fetch and for reads.
- Reset (`reset` = 0 at an edge), including mid-access:
  - state = IDLE; `cnt` = 0;
  - `gnt`, `done`, `mem_en`, `mem_we`, `busy` = 0;
  - `mem_addr`, `mem_wdata`, `mem_be`, `rdata` = 0;
  - the in-flight access is dropped and no `done` is issued.
- `be` = 0 on a write is legal: the access proceeds and `done` is issued.

## Timing
- Request present in cycle C0 (state IDLE):
  - `gnt` and `mem_en` in C1;
  - `done` in C1+MEM_LAT;
  - state returns to IDLE in C2+MEM_LAT.
- Access occupancy is MEM_LAT+2 cycles; back-to-back `gnt` spacing is MEM_LAT+2.
- `rdata` samples `mem_rdata` at the end of cycle C0+MEM_LAT. For MEM_LAT = 2, that is the end of C2.
- `busy` is registered. It is high from C1 through C1+MEM_LAT inclusive.
- `gnt` and `done` are never both nonzero in the same cycle.
- Only one bit of `gnt` is ever set; the same holds for `done`.

## Configuration
- Macro: `MEM_PORT_ARBITER_RR_EN`.
- **Defined:** round-robin arbitration.
  - A 2-bit pointer `last` holds the most recent winner and resets to debug (bit2).
  - Search order starts at the requester after `last` and wraps: fetch → data → debug → fetch.
  - `last` updates on each acceptance.
- **Undefined:** fixed priority (data > fetch > debug); the pointer logic is absent.

## Test plan
- Reset, then `req` = 3'b001 with `addr_f` = 0x10; memory returns 0xE7F0_0001 → `gnt` = 001 at C1 with `mem_en` = 1 and `mem_addr` = 0x10; `done` = 001 at C3; `rdata` = 0xE7F0_0001.
- `req` = 3'b111 held continuously:
  - without the macro, the grant sequence is data, data, data;
  - with `MEM_PORT_ARBITER_RR_EN`, the sequence is fetch, data, debug, fetch;
  - `gnt` spacing is 4 cycles in both cases.
- Data write with `addr_d` = 0x200, `wdata_d` = 0xDEADBEEF, `be_d` = 4'b0011 → `mem_we` = 1 and fields held through C3; `rdata` keeps its previous value.
- Pull `reset` low in C2 of a read → the next cycle shows all outputs 0 and state IDLE; `done` never pulses; a subsequent request is served normally.
- MEM_LAT = 1 and MEM_LAT = 5 builds with a single fetch → `done` at C2 and at C6 respectively.
- Change `addr_d` to 0x300 in the cycle after `gnt` → `mem_addr` stays at the original 0x200 until `done`.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external-memory port between fetch (req[0]),
// data (req[1]) and debug loader (req[2]). Each access is serialised: the
// winner's fields are latched into the mem_* registers, held for MEM_LAT
// cycles, and a one-hot gnt/done pair brackets the access.
// Optional build macro MEM_PORT_ARBITER_RR_EN selects round-robin arbitration
// (fetch -> data -> debug -> fetch); without it, fixed priority data > fetch > debug.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        req,
  input  logic [ADDR_W-1:0] addr_f,
  input  logic [ADDR_W-1:0] addr_d,
  input  logic [ADDR_W-1:0] addr_g,
  input  logic [DATA_W-1:0] wdata_d,
  input  logic [DATA_W-1:0] wdata_g,
  input  logic              we_d,
  input  logic              we_g,
  input  logic [3:0]        be_d,
  input  logic [3:0]        be_g,
  output logic [2:0]        gnt,
  output logic [2:0]        done,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] cnt;   // remaining access cycles, loaded with MEM_LAT
  logic [2:0] win;   // one-hot winner of the access in flight
  logic [2:0] pick;  // one-hot winner among the current requests

`ifdef MEM_PORT_ARBITER_RR_EN
  logic [1:0] last;      // most recent winner index: 0 fetch, 1 data, 2 debug
  logic [2:0] rot;       // requests rotated so bit0 is the first candidate
  logic [2:0] rot_pick;

  // Rotate the request vector to start after the last winner, take the lowest set bit, rotate back.
  always_comb begin
    rot = req;
    pick = 3'b000;
    case (last)
      2'd0:    rot = {req[0], req[2], req[1]};
      2'd1:    rot = {req[1], req[0], req[2]};
      default: rot = req;
    endcase
    rot_pick = rot & (~rot + 3'd1);
    case (last)
      2'd0:    pick = {rot_pick[1], rot_pick[0], rot_pick[2]};
      2'd1:    pick = {rot_pick[0], rot_pick[2], rot_pick[1]};
      default: pick = rot_pick;
    endcase
  end

  // Remember the winner of every accepted request; after reset the search begins at fetch.
  always_ff @(posedge clock) begin
    if (!reset) begin
      last <= 2'd2;
    end else if (state == IDLE && req != 3'b000) begin
      last <= pick[1] ? 2'd1 : (pick[2] ? 2'd2 : 2'd0);
    end
  end
`else
  // Fixed priority: data first, then fetch, then debug.
  always_comb begin
    pick = 3'b000;
    if (req[1])      pick = 3'b010;
    else if (req[0]) pick = 3'b001;
    else if (req[2]) pick = 3'b100;
  end
`endif

  // Access sequencer: latch winner, hold the port for MEM_LAT cycles, pulse done, return to idle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      win       <= 3'b000;
      gnt       <= 3'b000;
      done      <= 3'b000;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= 4'b0000;
      rdata     <= '0;
    end else begin
      gnt    <= 3'b000;
      done   <= 3'b000;
      mem_en <= 1'b0;
      case (state)
        IDLE: begin
          if (req != 3'b000) begin
            win    <= pick;
            gnt    <= pick;
            mem_en <= 1'b1;
            busy   <= 1'b1;
            cnt    <= 4'(MEM_LAT);
            state  <= ACCESS;
            if (pick[1]) begin
              mem_addr  <= addr_d;
              mem_we    <= we_d;
              mem_wdata <= we_d ? wdata_d : '0;
              mem_be    <= be_d;
            end else if (pick[2]) begin
              mem_addr  <= addr_g;
              mem_we    <= we_g;
              mem_wdata <= we_g ? wdata_g : '0;
              mem_be    <= be_g;
            end else begin
              // Fetch is a full-word read.
              mem_addr  <= addr_f;
              mem_we    <= 1'b0;
              mem_wdata <= '0;
              mem_be    <= 4'b1111;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (!mem_we) rdata <= mem_rdata;
            done  <= win;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
